uart_console_ctrl: RTL
======================

Name: uart_console_ctrl

Overview:
Sequencer that owns the register port of the simulation 8250 UART. After reset it programs the UART: divisor, 8N1 line format, FIFO control and interrupts off. It then drains a byte stream from the core/debug side into the transmit register. Before every transmit write it polls LSR.THRE, with a bounded retry count and a sticky error on timeout.

Parameters:
DIVISOR, 16'h000C, baud divisor written to DLL (low byte) and DLM (high byte).
FIFO_DEPTH, 4, depth of the transmit byte FIFO; must be a power of two, at least 2.
POLL_MAX, 255, maximum number of LSR polls per byte before the byte is dropped; range 1..65535.

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
tx_valid  in  1  byte offered by the requester
tx_data  in  8  byte to transmit
tx_ready  out  1  FIFO can accept a byte; push happens on tx_valid & tx_ready
init_done  out  1  init sequence complete; stays high until reset
busy  out  1  FIFO non-empty or FSM not in IDLE
tx_err  out  1  sticky flag; set when a byte is dropped by poll timeout
u_rvalid  out  1  UART read strobe
u_raddr  out  3  UART read register address
u_rdata  in  8  UART read data; valid in the cycle after the u_rvalid cycle
u_wvalid  out  1  UART write strobe
u_waddr  out  3  UART write register address
u_wdata  out  8  UART write data

Behaviour:
- All u_* outputs are registered, with at most one strobe (u_rvalid or u_wvalid) per cycle.
- Reset values: u_rvalid=0, u_wvalid=0, u_raddr=0, u_waddr=0, u_wdata=0, init_done=0, tx_err=0, FIFO empty, tx_ready=0, busy=1, FSM=INIT0, poll counter=0.
- Init: states INIT0..INIT5 issue one write per cycle, in this order:
  - INIT0: LCR(3) = 8'h80, setting DLAB.
  - INIT1: DLL(0) = DIVISOR[7:0].
  - INIT2: DLM(1) = DIVISOR[15:8].
  - INIT3: LCR(3) = 8'h03, giving 8N1 with DLAB clear.
  - INIT4: FCR(2) = 8'h07.
  - INIT5: IER(1) = 8'h00.
  - The cycle after the INIT5 strobe, the FSM enters IDLE and init_done goes to 1.
- First write strobe appears in the first cycle after rstn is sampled high. Init takes 6 cycles total.
- FIFO:
  - tx_ready = !full, independent of FSM state, so bytes are accepted and buffered during init.
  - Push and pop in the same cycle: both take effect and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.
- IDLE: if the FIFO is non-empty, go to POLL; otherwise stay.
- POLL:
  - Drives u_rvalid=1 and u_raddr=LSR(5) for exactly one cycle, then goes to CHECK.
  - The poll counter increments on each POLL.
- CHECK: samples u_rdata and drives no strobe.
  - u_rdata[5]=1 (THRE): go to WRITE.
  - u_rdata[5]=0 and poll counter < POLL_MAX: go to POLL.
  - u_rdata[5]=0 and poll counter == POLL_MAX: pop the FIFO head (byte dropped), set tx_err, clear the poll counter, go to IDLE.
- WRITE:
  - Drives u_wvalid=1, u_waddr=THR(0), u_wdata=FIFO head for one cycle.
  - Pops the FIFO in the same cycle, clears the poll counter, returns to IDLE.
- Minimum per-byte latency (IDLE to THR strobe) is 3 cycles: POLL, CHECK, WRITE. Back-to-back bytes take 4 cycles each, IDLE included.
- DLAB is never set after init, so THR writes always reach the transmitter.
- No register other than LSR is ever read. No register other than THR is written after init.
- Reset mid-operation (any state): all state returns to reset values and buffered bytes are discarded. An in-flight strobe is deasserted in the reset cycle. The full init sequence replays from INIT0.
- tx_err clears only on reset.

Test Plan:
- Reset 3 cycles, then release: required write sequence on consecutive cycles is (3,80),(0,0C),(1,00),(3,03),(2,07),(1,00); init_done=1 the next cycle; no u_rvalid during init.
- After init, push 8'h41 with LSR model returning 8'h60: u_rvalid with raddr=5, then one idle-strobe cycle, then u_wvalid with waddr=0 and wdata=41. tx_ready stays 1 and busy drops after the pop.
- LSR model returns 8'h00 for 5 polls, then 8'h20: exactly 6 LSR reads, then a single THR write of the byte; tx_err stays 0.
- Push 5 bytes (01..05) during init with FIFO_DEPTH=4:
  - tx_ready=0 after the 4th push, so the 5th is held.
  - THR writes occur in order 01,02,03,04, then 05 once space frees.
- POLL_MAX=3 with LSR stuck at 8'h00 and bytes AA, BB queued:
  - 3 reads, then AA is dropped and tx_err=1.
  - Once LSR returns 8'h20, BB is written.
- Assert rstn=0 in the CHECK state with 2 bytes queued: FIFO empties, no THR write occurs, init replays from the LCR=80 write after release.

Source files
------------

// File: rtl/uart_console_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_console_ctrl: programs an 8250 UART, then drains a byte FIFO into THR |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_console_ctrl #(
    parameter logic [15:0] DIVISOR    = 16'h000C,
    parameter int          FIFO_DEPTH = 4,
    parameter int          POLL_MAX   = 255
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       init_done,
    output logic       busy,
    output logic       tx_err,
    output logic       u_rvalid,
    output logic [2:0] u_raddr,
    input  logic [7:0] u_rdata,
    output logic       u_wvalid,
    output logic [2:0] u_waddr,
    output logic [7:0] u_wdata
);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);

    localparam logic [2:0] REG_THR = 3'd0;
    localparam logic [2:0] REG_DLL = 3'd0;
    localparam logic [2:0] REG_DLM = 3'd1;
    localparam logic [2:0] REG_IER = 3'd1;
    localparam logic [2:0] REG_FCR = 3'd2;
    localparam logic [2:0] REG_LCR = 3'd3;
    localparam logic [2:0] REG_LSR = 3'd5;

    typedef enum logic [3:0] {
        S_INIT0 = 4'd0,
        S_INIT1 = 4'd1,
        S_INIT2 = 4'd2,
        S_INIT3 = 4'd3,
        S_INIT4 = 4'd4,
        S_INIT5 = 4'd5,
        S_IDLE  = 4'd6,
        S_POLL  = 4'd7,
        S_CHECK = 4'd8,
        S_WRITE = 4'd9
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_nxt;
    logic            push;
    logic            pop;
    logic [15:0]     poll_cnt;
    logic [15:0]     poll_nxt;
    logic            err_set;
    logic            rvalid_nxt;
    logic            wvalid_nxt;
    logic [2:0]      raddr_nxt;
    logic [2:0]      waddr_nxt;
    logic [7:0]      wdata_nxt;

    assign push = tx_valid & tx_ready;
    assign busy = !init_done || (count != '0) || (state != S_IDLE);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count    <= count_nxt;
            tx_ready <= (count_nxt != FULL_COUNT);
        end
    end

    // Strobes are registered: init writes appear the cycle after their INIT
    // state, while POLL/WRITE strobes are raised on entry so they coincide
    // with the state that owns them.
    always_comb begin
        state_nxt  = state;
        rvalid_nxt = 1'b0;
        raddr_nxt  = u_raddr;
        wvalid_nxt = 1'b0;
        waddr_nxt  = u_waddr;
        wdata_nxt  = u_wdata;
        pop        = 1'b0;
        poll_nxt   = poll_cnt;
        err_set    = 1'b0;
        case (state)
            S_INIT0: begin
                wvalid_nxt = 1'b1;
                waddr_nxt  = REG_LCR;
                wdata_nxt  = 8'h80;
                state_nxt  = S_INIT1;
            end
            S_INIT1: begin
                wvalid_nxt = 1'b1;
                waddr_nxt  = REG_DLL;
                wdata_nxt  = DIVISOR[7:0];
                state_nxt  = S_INIT2;
            end
            S_INIT2: begin
                wvalid_nxt = 1'b1;
                waddr_nxt  = REG_DLM;
                wdata_nxt  = DIVISOR[15:8];
                state_nxt  = S_INIT3;
            end
            S_INIT3: begin
                wvalid_nxt = 1'b1;
                waddr_nxt  = REG_LCR;
                wdata_nxt  = 8'h03;
                state_nxt  = S_INIT4;
            end
            S_INIT4: begin
                wvalid_nxt = 1'b1;
                waddr_nxt  = REG_FCR;
                wdata_nxt  = 8'h07;
                state_nxt  = S_INIT5;
            end
            S_INIT5: begin
                wvalid_nxt = 1'b1;
                waddr_nxt  = REG_IER;
                wdata_nxt  = 8'h00;
                state_nxt  = S_IDLE;
            end
            S_IDLE: begin
                // Service waits for init_done so the last init write has retired.
                if (init_done && (count != '0)) begin
                    rvalid_nxt = 1'b1;
                    raddr_nxt  = REG_LSR;
                    state_nxt  = S_POLL;
                end
            end
            S_POLL: begin
                poll_nxt  = poll_cnt + 16'd1;
                state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (u_rdata[5]) begin
                    wvalid_nxt = 1'b1;
                    waddr_nxt  = REG_THR;
                    wdata_nxt  = mem[rd_ptr];
                    state_nxt  = S_WRITE;
                end else if (poll_cnt < POLL_LIMIT) begin
                    rvalid_nxt = 1'b1;
                    raddr_nxt  = REG_LSR;
                    state_nxt  = S_POLL;
                end else begin
                    pop       = 1'b1;
                    err_set   = 1'b1;
                    poll_nxt  = 16'd0;
                    state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                pop       = 1'b1;
                poll_nxt  = 16'd0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_INIT0;
            poll_cnt  <= 16'd0;
            init_done <= 1'b0;
            tx_err    <= 1'b0;
            u_rvalid  <= 1'b0;
            u_raddr   <= 3'd0;
            u_wvalid  <= 1'b0;
            u_waddr   <= 3'd0;
            u_wdata   <= 8'h00;
        end else begin
            state     <= state_nxt;
            poll_cnt  <= poll_nxt;
            init_done <= init_done | (state == S_IDLE);
            tx_err    <= tx_err | err_set;
            u_rvalid  <= rvalid_nxt;
            u_raddr   <= raddr_nxt;
            u_wvalid  <= wvalid_nxt;
            u_waddr   <= waddr_nxt;
            u_wdata   <= wdata_nxt;
        end
    end
endmodule
`default_nettype wire
